// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampled UART receiver (8N1, optional even parity via the
//            UART_RX_PARITY_EN macro) with a one-entry valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 overrun
);

   localparam int c_TW = $clog2(OVERSAMPLE);
   localparam int c_BW = $clog2(DATA_BITS + 1);
   localparam logic [c_TW-1:0] c_T_LAST = c_TW'(OVERSAMPLE - 1);
   localparam logic [c_TW-1:0] c_T_HALF = c_TW'(OVERSAMPLE / 2 - 1);
   localparam logic [c_BW-1:0] c_B_LAST = c_BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;

   logic                 r_sync1, r_sync2;
   logic                 w_rxd_s;
   state_t               r_state, w_state_nxt;
   logic [c_TW-1:0]      r_tcnt, w_tcnt_nxt;
   logic [c_BW-1:0]      r_bcnt, w_bcnt_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 w_deliver;
   logic [DATA_BITS-1:0] w_data_nxt;
   logic                 w_valid_nxt, w_ferr_nxt, w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
   logic                 r_par, w_par_nxt;
   logic                 w_perr_nxt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxd_s = r_sync2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_tcnt  <= '0;
         r_bcnt  <= '0;
         r_shift <= '0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_bcnt_nxt  = r_bcnt;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      if (tick) begin
         case (r_state)
            ST_IDLE: begin
               if (!w_rxd_s) begin
                  w_state_nxt = ST_START;
                  w_tcnt_nxt  = '0;
               end
            end
            ST_START: begin
               if (r_tcnt == c_T_HALF) begin
                  // A start bit that is high again at mid-bit was only a glitch
                  if (w_rxd_s) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_state_nxt = ST_DATA;
                     w_tcnt_nxt  = '0;
                     w_bcnt_nxt  = '0;
                  end
               end else begin
                  w_tcnt_nxt = r_tcnt + c_TW'(1);
               end
            end
            ST_DATA: begin
               if (r_tcnt == c_T_LAST) begin
                  w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                  w_tcnt_nxt  = '0;
                  w_bcnt_nxt  = r_bcnt + c_BW'(1);
                  if (r_bcnt == c_B_LAST) begin
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = ST_PARITY;
`else
                     w_state_nxt = ST_STOP;
`endif
                  end
               end else begin
                  w_tcnt_nxt = r_tcnt + c_TW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (r_tcnt == c_T_LAST) begin
                  w_par_nxt   = w_rxd_s;
                  w_tcnt_nxt  = '0;
                  w_state_nxt = ST_STOP;
               end else begin
                  w_tcnt_nxt = r_tcnt + c_TW'(1);
               end
            end
`endif
            ST_STOP: begin
               if (r_tcnt == c_T_LAST) begin
                  w_deliver   = 1'b1;
                  w_tcnt_nxt  = '0;
                  // A low stop bit may be a break; hold off until the line idles
                  w_state_nxt = w_rxd_s ? ST_IDLE : ST_WAIT_HIGH;
               end else begin
                  w_tcnt_nxt = r_tcnt + c_TW'(1);
               end
            end
            ST_WAIT_HIGH: begin
               if (w_rxd_s) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_valid_nxt = valid;
      w_data_nxt  = data;
      w_ferr_nxt  = frame_err;
      w_ovr_nxt   = overrun;
`ifdef UART_RX_PARITY_EN
      w_perr_nxt  = parity_err;
`endif
      if (valid && ready) begin
         w_valid_nxt = 1'b0;
         w_ovr_nxt   = 1'b0;
      end
      // Delivery is evaluated after the handshake so a set of overrun wins
      if (w_deliver) begin
         if (!valid || ready) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
            w_ferr_nxt  = ~w_rxd_s;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = (^r_shift) ^ r_par;
`endif
         end else begin
            w_ovr_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data       <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         data       <= w_data_nxt;
         valid      <= w_valid_nxt;
         frame_err  <= w_ferr_nxt;
         overrun    <= w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
         parity_err <= w_perr_nxt;
`endif
      end
   end

endmodule
`default_nettype wire
